// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller arbitrating load/store and instruction fetch
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        lsb_req,
    input  logic        lsb_is_store,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_data,
    input  logic [2:0]  lsb_op,
    output logic        lsb_res_avail,
    output logic [31:0] lsb_res,
    output logic        mem_stuck,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_res_avail,
    output logic [31:0] if_res,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STORE = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [2:0]  op_r;
    logic [23:0] data_hi;
    logic [31:0] buf_r;
    logic [31:0] assembled;
    logic [31:0] load_ext;
    logic [1:0]  din_idx;
    logic        din_vld;
    logic        lsb_pend;
    logic        if_pend;
    logic        killed;
    logic        reading;
    logic        store_blocked;

    function automatic logic [2:0] bytes_of(input logic [1:0] sz);
        case (sz)
            2'b00:   bytes_of = 3'd1;
            2'b01:   bytes_of = 3'd2;
            default: bytes_of = 3'd4;
        endcase
    endfunction

    assign reading       = (state == S_LOAD || state == S_FETCH) && (cnt < n_bytes);
    assign store_blocked = lsb_is_store && io_buffer_full &&
                           (lsb_addr == 32'h0003_0000 || lsb_addr == 32'h0003_0004);
    assign mem_stuck     = io_buffer_full;
    assign mem_wr        = (state == S_STORE) && rdy_in;
    assign lsb_res_avail = lsb_pend && rdy_in && !rob_clear;
    assign if_res_avail  = if_pend && rdy_in && !rob_clear;

    always_comb begin
        assembled = buf_r;
        if (din_vld) begin
            assembled[{din_idx, 3'b000} +: 8] = mem_din;
        end
        load_ext = assembled;
        case (op_r[1:0])
            2'b00:   load_ext = {{24{!op_r[2] && assembled[7]}}, assembled[7:0]};
            2'b01:   load_ext = {{16{!op_r[2] && assembled[15]}}, assembled[15:0]};
            default: load_ext = assembled;
        endcase
    end

    // The RAM answers every cycle, stalled or not, so track which byte mem_din
    // carries and keep it; mem_a is held during a stall so the data stays valid.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            din_vld <= 1'b0;
            din_idx <= 2'd0;
            buf_r   <= 32'd0;
        end else begin
            din_vld <= reading;
            din_idx <= cnt[1:0];
            if (din_vld) begin
                buf_r[{din_idx, 3'b000} +: 8] <= mem_din;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            n_bytes  <= 3'd4;
            op_r     <= 3'd0;
            data_hi  <= 24'd0;
            mem_a    <= 32'd0;
            mem_dout <= 8'd0;
            lsb_pend <= 1'b0;
            if_pend  <= 1'b0;
            killed   <= 1'b0;
            lsb_res  <= 32'd0;
            if_res   <= 32'd0;
        end else if (rdy_in) begin
            case (state)
                S_IDLE: begin
                    if (!rob_clear) begin
                        if (lsb_req && !store_blocked) begin
                            state    <= lsb_is_store ? S_STORE : S_LOAD;
                            mem_a    <= lsb_addr;
                            cnt      <= 3'd0;
                            n_bytes  <= bytes_of(lsb_op[1:0]);
                            op_r     <= lsb_op;
                            data_hi  <= lsb_data[31:8];
                            mem_dout <= lsb_data[7:0];
                            killed   <= 1'b0;
                        end else if (if_req) begin
                            state   <= S_FETCH;
                            mem_a   <= if_addr;
                            cnt     <= 3'd0;
                            n_bytes <= 3'd4;
                            op_r    <= 3'b010;
                        end
                    end
                end
                S_LOAD, S_FETCH: begin
                    if (rob_clear) begin
                        state <= S_IDLE;
                    end else if (cnt == n_bytes) begin
                        state <= S_DONE;
                        if (state == S_LOAD) begin
                            lsb_pend <= 1'b1;
                            lsb_res  <= load_ext;
                        end else begin
                            if_pend <= 1'b1;
                            if_res  <= assembled;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt + 3'd1 < n_bytes) begin
                            mem_a <= mem_a + 32'd1;
                        end
                    end
                end
                S_STORE: begin
                    // A flushed store still writes every byte; only its completion is dropped.
                    if (cnt == n_bytes - 3'd1) begin
                        state    <= S_DONE;
                        lsb_pend <= !(killed || rob_clear);
                    end else begin
                        cnt    <= cnt + 3'd1;
                        mem_a  <= mem_a + 32'd1;
                        killed <= killed || rob_clear;
                        case (cnt[1:0])
                            2'd0:    mem_dout <= data_hi[7:0];
                            2'd1:    mem_dout <= data_hi[15:8];
                            default: mem_dout <= data_hi[23:16];
                        endcase
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    lsb_pend <= 1'b0;
                    if_pend  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array RAM model
module tb_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic        lsb_req = 1'b0;
    logic        lsb_is_store = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_data = 32'd0;
    logic [2:0]  lsb_op = 3'd0;
    logic        lsb_res_avail;
    logic [31:0] lsb_res;
    logic        mem_stuck;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_res_avail;
    logic [31:0] if_res;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    logic [7:0]  ram [0:65535];
    logic [39:0] wlog [$];

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .lsb_req(lsb_req), .lsb_is_store(lsb_is_store), .lsb_addr(lsb_addr),
        .lsb_data(lsb_data), .lsb_op(lsb_op), .lsb_res_avail(lsb_res_avail),
        .lsb_res(lsb_res), .mem_stuck(mem_stuck), .if_req(if_req), .if_addr(if_addr),
        .if_res_avail(if_res_avail), .if_res(if_res), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) begin
            ram[mem_a[15:0]] = mem_dout;
            wlog.push_back({mem_a, mem_dout});
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
        int n;
        longint unsigned v;
        longint unsigned half;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        v = 0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai;
            ai = a + 32'(i);
            v += longint'(ram[ai[15:0]]) << (8 * i);
        end
        if (n < 4 && !op[2]) begin
            half = 64'd1 << (8 * n - 1);
            if (v >= half) v = v + 64'h1_0000_0000 - 2 * half;
        end
        return v[31:0];
    endfunction

    function automatic logic pick_rdy(input int pct);
        return (pct == 0) || ($urandom_range(99) >= pct);
    endfunction

    task automatic run_lsb(input bit st, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] op, input int pct, input string nm);
        int n, lat, edges, extra;
        bit seen, ok;
        logic [31:0] exp;
        n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        lat = st ? n + 1 : n + 2;
        exp = ref_load(a, op);
        edges = 0; seen = 0; extra = 0;
        @(negedge clk_in);
        wlog.delete();
        lsb_req = 1; lsb_is_store = st; lsb_addr = a; lsb_data = d; lsb_op = op;
        rdy_in = pick_rdy(pct);
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk_in);
            if (rdy_in) edges++;
            if (lsb_res_avail) begin
                seen = 1; lsb_req = 0;
                n_checks++;
                if (edges != lat) $display("FAIL %s latency: got %0d edges required %0d", nm, edges, lat);
                else n_pass++;
                if (!st) begin
                    n_checks++;
                    if (lsb_res !== exp) $display("FAIL %s data: got %h required %h", nm, lsb_res, exp);
                    else n_pass++;
                end
            end
            rdy_in = seen ? 1'b1 : pick_rdy(pct);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s timeout: got no lsb_res_avail required one", nm);
            lsb_req = 0;
        end
        rdy_in = 1;
        repeat (4) begin
            @(negedge clk_in);
            if (lsb_res_avail) extra++;
        end
        n_checks++;
        if (extra != 0) $display("FAIL %s extra pulse: got %0d required 0", nm, extra);
        else n_pass++;
        if (st) begin
            ok = (wlog.size() == n);
            for (int i = 0; i < n && ok; i++)
                if (wlog[i] !== {a + 32'(i), d[8*i +: 8]}) ok = 0;
            n_checks++;
            if (!ok) $display("FAIL %s writes: got %0d writes first %h required %0d", nm, wlog.size(),
                              (wlog.size() > 0) ? wlog[0] : 40'd0, n);
            else n_pass++;
        end
    endtask

    task automatic run_fetch(input logic [31:0] a, input int pct, input string nm);
        int edges;
        bit seen;
        logic [31:0] exp;
        exp = ref_load(a, 3'b010);
        edges = 0; seen = 0;
        @(negedge clk_in);
        if_req = 1; if_addr = a;
        rdy_in = pick_rdy(pct);
        for (int c = 0; c < 80 && !seen; c++) begin
            @(negedge clk_in);
            if (rdy_in) edges++;
            if (if_res_avail) begin
                seen = 1; if_req = 0;
                n_checks++;
                if (edges != 6 || if_res !== exp)
                    $display("FAIL %s: got %0d edges %h required 6 edges %h", nm, edges, if_res, exp);
                else n_pass++;
            end
            rdy_in = seen ? 1'b1 : pick_rdy(pct);
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s timeout: got no if_res_avail required one", nm);
            if_req = 0;
        end
        rdy_in = 1;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_in);
        n_checks++;
        if ({mem_a, mem_dout, mem_wr, lsb_res_avail, if_res_avail, lsb_res, if_res} !== 107'd0)
            $display("FAIL reset outputs: got a=%h dout=%h wr=%b la=%b ia=%b lr=%h ir=%h required all 0",
                     mem_a, mem_dout, mem_wr, lsb_res_avail, if_res_avail, lsb_res, if_res);
        else n_pass++;
        rst_in = 1;
        @(negedge clk_in);
    endtask

    task automatic test_directed();
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
        ram[16'h0200] = 8'h01; ram[16'h0201] = 8'h80;
        run_lsb(0, 32'h100, 0, 3'b010, 0, "lw_0x100");
        run_lsb(0, 32'h201, 0, 3'b000, 0, "lb_0x80");
        run_lsb(0, 32'h201, 0, 3'b100, 0, "lbu_0x80");
        run_lsb(0, 32'h200, 0, 3'b001, 0, "lh_0x8001");
        run_lsb(1, 32'h300, 32'hDEAD_BEEF, 3'b010, 0, "sw_0x300");
        run_lsb(0, 32'h300, 0, 3'b010, 0, "lw_back_0x300");
        run_lsb(0, 32'hFFFF_FFFE, 0, 3'b010, 0, "lw_wrap");
        run_lsb(1, 32'hFFFF_FFFF, 32'h0000_A55A, 3'b001, 0, "sh_wrap");
    endtask

    task automatic test_random_lsb();
        logic [2:0] ops [8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 40; i++) begin
            bit st;
            logic [2:0] op;
            st = ($urandom_range(2) == 0);
            op = ops[$urandom_range(7)];
            if (st) op[2] = 1'b0;
            run_lsb(st, {16'd0, 16'($urandom)}, $urandom, op, (i < 20) ? 0 : 35, "rand_lsb");
        end
    endtask

    task automatic test_random_fetch();
        for (int i = 0; i < 10; i++)
            run_fetch($urandom, (i < 5) ? 0 : 35, "rand_fetch");
    endtask

    task automatic test_priority();
        int lc, ic, ln, in_;
        logic [31:0] lv, iv, el, ef;
        lc = -1; ic = -1; ln = 0; in_ = 0; lv = 0; iv = 0;
        el = ref_load(32'h100, 3'b010);
        ef = ref_load(32'h204, 3'b010);
        @(negedge clk_in);
        lsb_req = 1; lsb_is_store = 0; lsb_addr = 32'h100; lsb_op = 3'b010;
        if_req = 1; if_addr = 32'h204;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk_in);
            if (lsb_res_avail) begin ln++; lc = c; lv = lsb_res; lsb_req = 0; end
            if (if_res_avail) begin in_++; ic = c; iv = if_res; if_req = 0; end
        end
        lsb_req = 0; if_req = 0;
        n_checks++;
        if (lc != 6 || ln != 1 || lv !== el)
            $display("FAIL prio_lsb: got cyc %0d cnt %0d val %h required cyc 6 cnt 1 val %h", lc, ln, lv, el);
        else n_pass++;
        n_checks++;
        if (ic != 13 || in_ != 1 || iv !== ef)
            $display("FAIL prio_fetch: got cyc %0d cnt %0d val %h required cyc 13 cnt 1 val %h", ic, in_, iv, ef);
        else n_pass++;
    endtask

    task automatic test_io_block();
        int stray, pc, fc;
        stray = 0; pc = -1; fc = -1;
        @(negedge clk_in);
        wlog.delete();
        io_buffer_full = 1;
        lsb_req = 1; lsb_is_store = 1; lsb_addr = 32'h3_0000; lsb_data = 32'h5A; lsb_op = 3'b000;
        repeat (5) begin
            @(negedge clk_in);
            if (lsb_res_avail) stray++;
        end
        n_checks++;
        if (stray != 0 || wlog.size() != 0 || mem_stuck !== 1'b1)
            $display("FAIL io_blocked: got pulses %0d writes %0d stuck %b required 0 0 1", stray, wlog.size(), mem_stuck);
        else n_pass++;
        io_buffer_full = 0;
        for (int c = 1; c <= 10 && pc < 0; c++) begin
            @(negedge clk_in);
            if (lsb_res_avail) begin pc = c; lsb_req = 0; end
        end
        lsb_req = 0;
        n_checks++;
        if (pc != 2 || wlog.size() != 1 || wlog[0] !== {32'h3_0000, 8'h5A})
            $display("FAIL io_release: got pulse %0d writes %0d required pulse 2 one write to 30000=5a", pc, wlog.size());
        else n_pass++;
        @(negedge clk_in);
        wlog.delete();
        io_buffer_full = 1; stray = 0;
        lsb_req = 1; lsb_is_store = 1; lsb_addr = 32'h3_0004; lsb_data = 32'h77; lsb_op = 3'b000;
        if_req = 1; if_addr = 32'h40;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (if_res_avail) begin fc = c; if_req = 0; end
            if (lsb_res_avail) stray++;
        end
        n_checks++;
        if (fc != 6 || stray != 0 || wlog.size() != 0)
            $display("FAIL io_fetch_bypass: got fetch %0d lsb %0d writes %0d required 6 0 0", fc, stray, wlog.size());
        else n_pass++;
        lsb_req = 0; if_req = 0; io_buffer_full = 0;
        @(negedge clk_in);
    endtask

    task automatic test_rob_clear();
        int pulses, wrs;
        bit ok;
        pulses = 0; wrs = 0;
        @(negedge clk_in);
        lsb_req = 1; lsb_is_store = 0; lsb_addr = 32'h100; lsb_op = 3'b010;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk_in);
            if (lsb_res_avail) pulses++;
            if (mem_wr) wrs++;
            if (c == 3) begin rob_clear = 1; lsb_req = 0; end
            if (c == 4) rob_clear = 0;
        end
        n_checks++;
        if (pulses != 0 || wrs != 0)
            $display("FAIL flush_load: got pulses %0d wr %0d required 0 0", pulses, wrs);
        else n_pass++;
        run_lsb(0, 32'h104, 0, 3'b010, 0, "load_after_flush");
        pulses = 0;
        @(negedge clk_in);
        wlog.delete();
        lsb_req = 1; lsb_is_store = 1; lsb_addr = 32'h500; lsb_data = 32'h1234_5678; lsb_op = 3'b010;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (lsb_res_avail) pulses++;
            if (c == 2) begin rob_clear = 1; lsb_req = 0; end
            if (c == 3) rob_clear = 0;
        end
        ok = (wlog.size() == 4);
        for (int i = 0; i < 4 && ok; i++)
            if (wlog[i] !== {32'h500 + 32'(i), 8'(32'h1234_5678 >> (8 * i))}) ok = 0;
        n_checks++;
        if (!ok || pulses != 0)
            $display("FAIL flush_store: got writes %0d pulses %0d required 4 writes 0 pulses", wlog.size(), pulses);
        else n_pass++;
    endtask

    task automatic test_stall();
        int pc;
        logic [31:0] exp, got;
        pc = -1; got = 0;
        exp = ref_load(32'h40, 3'b010);
        @(negedge clk_in);
        if_req = 1; if_addr = 32'h40;
        for (int c = 1; c <= 15 && pc < 0; c++) begin
            @(negedge clk_in);
            if (if_res_avail) begin pc = c; got = if_res; if_req = 0; end
            if (c == 2) rdy_in = 0;
            if (c == 5) rdy_in = 1;
        end
        if_req = 0; rdy_in = 1;
        n_checks++;
        if (pc != 9 || got !== exp)
            $display("FAIL stall_fetch: got cyc %0d word %h required cyc 9 word %h", pc, got, exp);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int pulses;
        pulses = 0;
        @(negedge clk_in);
        lsb_req = 1; lsb_is_store = 0; lsb_addr = 32'h100; lsb_op = 3'b010;
        repeat (2) @(negedge clk_in);
        #2 rst_in = 0;
        #1;
        n_checks++;
        if ({mem_a, mem_wr, lsb_res, if_res, lsb_res_avail} !== 98'd0)
            $display("FAIL async_reset: got a=%h wr=%b lr=%h ir=%h la=%b required all 0",
                     mem_a, mem_wr, lsb_res, if_res, lsb_res_avail);
        else n_pass++;
        @(negedge clk_in);
        lsb_req = 0; rst_in = 1;
        repeat (8) begin
            @(negedge clk_in);
            if (lsb_res_avail || if_res_avail) pulses++;
        end
        n_checks++;
        if (pulses != 0) $display("FAIL reset_abort: got %0d pulses required 0", pulses);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        test_reset();
        test_directed();
        test_random_lsb();
        test_random_fetch();
        test_priority();
        test_io_block();
        test_rob_clear();
        test_stall();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
